// File: rtl/bmp_export_ctrl.sv
// bmp_export_ctrl: sequences a BMP frame export and owns the single frame-memory write port.
// Latency: start->CALC +1 cycle, hdr_start +2, done 1 cycle after pix_done; mem mux is zero-latency.
// Backpressure: start while busy is dropped; host waits for IDLE; start during a host grant is held pending.
// Ports: start/busy/done/err control; crop window in, latched window and sizes out;
//        hdr_*/pix_* sub-block handshakes and write requests; host_* arbitrated requester; mem_* shared port.
module bmp_export_ctrl #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int HDR_BYTES      = 54,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  input  logic [10:0]       xMin,
  input  logic [10:0]       xMax,
  input  logic [10:0]       yMin,
  input  logic [10:0]       yMax,
  output logic [10:0]       win_xMin,
  output logic [10:0]       win_xMax,
  output logic [10:0]       win_yMin,
  output logic [10:0]       win_yMax,
  output logic [12:0]       row_bytes,
  output logic [31:0]       image_bytes,
  output logic [31:0]       file_size,
  output logic [ADDR_W-1:0] pix_base,
  output logic              hdr_start,
  input  logic              hdr_done,
  input  logic [ADDR_W-1:0] hdr_addr,
  input  logic              hdr_wren,
  input  logic [DATA_W-1:0] hdr_wrdata,
  output logic              pix_start,
  input  logic              pix_done,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic              pix_wren,
  input  logic [DATA_W-1:0] pix_wrdata,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_wren,
  input  logic [DATA_W-1:0] host_wrdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wrdata
);

  typedef enum logic [2:0] {S_IDLE, S_HOST, S_CALC, S_HDR, S_PIX, S_DONE} state_t;

  localparam logic [19:0] TMO     = 20'(TIMEOUT_CYCLES);
  localparam logic [1:0]  ERR_OK  = 2'd0;
  localparam logic [1:0]  ERR_WIN = 2'd1;
  localparam logic [1:0]  ERR_TMO = 2'd2;

  state_t      r_state, w_next;
  logic        r_pend;
  logic [10:0] r_win_xmin, r_win_xmax, r_win_ymin, r_win_ymax;
  logic [12:0] r_row_bytes;
  logic [31:0] r_image_bytes, r_file_size;
  logic [1:0]  r_err;
  logic [19:0] r_wdog;
  logic        r_hdr_start, r_pix_start;

  logic        w_accept;
  logic        w_tmo;
  logic        w_bad;
  logic        w_phase_entry;
  logic [11:0] w_w, w_h;
  logic [13:0] w_row_raw;
  logic [12:0] w_row;
  logic [31:0] w_img;

  // Sizes are computed from the latched window; 12 bits holds W up to 2048.
  assign w_w       = {1'b0, r_win_xmax} - {1'b0, r_win_xmin} + 12'd1;
  assign w_h       = {1'b0, r_win_ymax} - {1'b0, r_win_ymin} + 12'd1;
  assign w_row_raw = 14'(w_w) * 14'd3 + 14'd3;
  assign w_row     = w_row_raw[12:0] & ~13'd3;
  assign w_img     = 32'(w_row) * 32'(w_h);
  assign w_bad     = (r_win_xmax < r_win_xmin) || (r_win_ymax < r_win_ymin);
  assign w_tmo     = (r_wdog == TMO);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A start latched during a host grant is treated exactly like a live start.
        if (start || r_pend) begin
          w_next   = S_CALC;
          w_accept = 1'b1;
        end else if (host_req) begin
          w_next = S_HOST;
        end
      end
      S_HOST:  if (!host_req) w_next = S_IDLE;
      S_CALC:  w_next = w_bad ? S_DONE : S_HDR;
      S_HDR:   if (hdr_done) w_next = S_PIX; else if (w_tmo) w_next = S_DONE;
      S_PIX:   if (pix_done) w_next = S_DONE; else if (w_tmo) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_phase_entry = (w_next != r_state) && ((w_next == S_HDR) || (w_next == S_PIX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pend        <= 1'b0;
      r_win_xmin    <= '0;
      r_win_xmax    <= '0;
      r_win_ymin    <= '0;
      r_win_ymax    <= '0;
      r_row_bytes   <= '0;
      r_image_bytes <= '0;
      r_file_size   <= '0;
      r_err         <= ERR_OK;
      r_wdog        <= '0;
      r_hdr_start   <= 1'b0;
      r_pix_start   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hdr_start <= (w_next == S_HDR) && (r_state != S_HDR);
      r_pix_start <= (w_next == S_PIX) && (r_state != S_PIX);

      // Saturate so a stalled phase cannot wrap past the limit.
      if (w_phase_entry)   r_wdog <= '0;
      else if (!w_tmo)     r_wdog <= r_wdog + 20'd1;

      if (w_accept)                          r_pend <= 1'b0;
      else if ((r_state == S_HOST) && start) r_pend <= 1'b1;

      if (w_accept) begin
        r_win_xmin <= xMin;
        r_win_xmax <= xMax;
        r_win_ymin <= yMin;
        r_win_ymax <= yMax;
        r_err      <= ERR_OK;
      end

      if (r_state == S_CALC) begin
        r_row_bytes   <= w_row;
        r_image_bytes <= w_img;
        r_file_size   <= w_img + 32'(HDR_BYTES);
        if (w_bad) r_err <= ERR_WIN;
      end

      if (((r_state == S_HDR) && !hdr_done && w_tmo) ||
          ((r_state == S_PIX) && !pix_done && w_tmo))
        r_err <= ERR_TMO;
    end
  end

  // Only the requester owning the current state reaches memory; everyone else is masked.
  always_comb begin
    mem_addr   = '0;
    mem_wren   = 1'b0;
    mem_wrdata = '0;
    unique case (r_state)
      S_HOST: begin
        mem_addr   = host_addr;
        mem_wren   = host_wren;
        mem_wrdata = host_wrdata;
      end
      S_HDR: begin
        mem_addr   = hdr_addr;
        mem_wren   = hdr_wren;
        mem_wrdata = hdr_wrdata;
      end
      S_PIX: begin
        mem_addr   = pix_addr;
        mem_wren   = pix_wren;
        mem_wrdata = pix_wrdata;
      end
      default: begin
        mem_addr   = '0;
        mem_wren   = 1'b0;
        mem_wrdata = '0;
      end
    endcase
  end

  assign busy        = (r_state == S_CALC) || (r_state == S_HDR) || (r_state == S_PIX);
  assign done        = (r_state == S_DONE);
  assign host_gnt    = (r_state == S_HOST);
  assign err         = r_err;
  assign hdr_start   = r_hdr_start;
  assign pix_start   = r_pix_start;
  assign win_xMin    = r_win_xmin;
  assign win_xMax    = r_win_xmax;
  assign win_yMin    = r_win_ymin;
  assign win_yMax    = r_win_ymax;
  assign row_bytes   = r_row_bytes;
  assign image_bytes = r_image_bytes;
  assign file_size   = r_file_size;
  assign pix_base    = ADDR_W'(HDR_BYTES);

endmodule

// File: tb/tb_bmp_export_ctrl.sv
`timescale 1ns/1ps
module tb_bmp_export_ctrl;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int HDR_BYTES = 54;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, busy, done;
  logic [1:0]        err;
  logic [10:0]       xMin, xMax, yMin, yMax;
  logic [10:0]       win_xMin, win_xMax, win_yMin, win_yMax;
  logic [12:0]       row_bytes;
  logic [31:0]       image_bytes, file_size;
  logic [ADDR_W-1:0] pix_base;
  logic              hdr_start, hdr_done, hdr_wren;
  logic [ADDR_W-1:0] hdr_addr;
  logic [DATA_W-1:0] hdr_wrdata;
  logic              pix_start, pix_done, pix_wren;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_wrdata;
  logic              host_req, host_gnt, host_wren;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wrdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wrdata;

  always #5 clk = ~clk;

  bmp_export_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HDR_BYTES(HDR_BYTES), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .win_xMin(win_xMin), .win_xMax(win_xMax), .win_yMin(win_yMin), .win_yMax(win_yMax),
    .row_bytes(row_bytes), .image_bytes(image_bytes), .file_size(file_size), .pix_base(pix_base),
    .hdr_start(hdr_start), .hdr_done(hdr_done), .hdr_addr(hdr_addr), .hdr_wren(hdr_wren), .hdr_wrdata(hdr_wrdata),
    .pix_start(pix_start), .pix_done(pix_done), .pix_addr(pix_addr), .pix_wren(pix_wren), .pix_wrdata(pix_wrdata),
    .host_req(host_req), .host_gnt(host_gnt), .host_addr(host_addr), .host_wren(host_wren), .host_wrdata(host_wrdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wrdata(mem_wrdata)
  );

  typedef struct {
    logic [1:0]  err;
    logic [10:0] x0, x1, y0, y1;
    logic [12:0] row;
    logic [31:0] img, file;
    bit          sizes;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_sel = 0;  // who should own memory: 0 none, 1 host, 2 header, 3 pixel

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: padded row = 3*W rounded up to a multiple of 4.
  function automatic exp_t model(input int x0, x1, y0, y1, input bit tmo);
    exp_t e;
    int w, h, row;
    e.x0 = 11'(x0); e.x1 = 11'(x1); e.y0 = 11'(y0); e.y1 = 11'(y1);
    e.row = '0; e.img = '0; e.file = '0;
    if (x1 < x0 || y1 < y0) begin
      e.err = 2'd1;
      e.sizes = 1'b0;
    end else begin
      w = x1 - x0 + 1;
      h = y1 - y0 + 1;
      row = ((3 * w + 3) / 4) * 4;
      e.row = 13'(row);
      e.img = 32'(row * h);
      e.file = 32'(row * h + HDR_BYTES);
      e.err = tmo ? 2'd2 : 2'd0;
      e.sizes = 1'b1;
    end
    return e;
  endfunction

  // Monitor: memory ownership every cycle, completion record on every done pulse.
  exp_t              m_e;
  logic [ADDR_W-1:0] m_a;
  logic              m_w;
  logic [DATA_W-1:0] m_d;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      m_a = '0; m_w = 1'b0; m_d = '0;
      case (exp_sel)
        1: begin m_a = host_addr; m_w = host_wren; m_d = host_wrdata; end
        2: begin m_a = hdr_addr;  m_w = hdr_wren;  m_d = hdr_wrdata;  end
        3: begin m_a = pix_addr;  m_w = pix_wren;  m_d = pix_wrdata;  end
        default: ;
      endcase
      chk("mem_wren", mem_wren, m_w);
      chk("mem_addr", mem_addr, m_a);
      chk("mem_wrdata", mem_wrdata, m_d);
      chk("host_gnt", host_gnt, exp_sel == 1);
      if (exp_sel != 2) chk("hdr_start_outside", hdr_start, 0);
      if (exp_sel != 3) chk("pix_start_outside", pix_start, 0);
      if (done === 1'b1) begin
        chk("sb_nonempty_at_done", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          m_e = sb_q.pop_front();
          chk("sb_err", err, m_e.err);
          chk("sb_win_xMin", win_xMin, m_e.x0);
          chk("sb_win_xMax", win_xMax, m_e.x1);
          chk("sb_win_yMin", win_yMin, m_e.y0);
          chk("sb_win_yMax", win_yMax, m_e.y1);
          if (m_e.sizes) begin
            chk("sb_row_bytes", row_bytes, m_e.row);
            chk("sb_image_bytes", image_bytes, m_e.img);
            chk("sb_file_size", file_size, m_e.file);
          end
        end
      end
    end
  end

  // Requesters present random write traffic all the time; only the owner may get through.
  initial begin
    forever begin
      @(posedge clk); #1;
      hdr_addr = ADDR_W'($urandom);  hdr_wren = 1'($urandom);  hdr_wrdata = DATA_W'($urandom);
      pix_addr = ADDR_W'($urandom);  pix_wren = 1'($urandom);  pix_wrdata = DATA_W'($urandom);
      host_addr = ADDR_W'($urandom); host_wren = 1'($urandom); host_wrdata = DATA_W'($urandom);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_win(input exp_t e);
    xMin = e.x0; xMax = e.x1; yMin = e.y0; yMax = e.y1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, err, hdr_start, pix_start, host_gnt, mem_wren}, 0);
    chk({tag, "_win"}, {win_xMin, win_xMax, win_yMin, win_yMax}, 0);
    chk({tag, "_row"}, row_bytes, 0);
    chk({tag, "_img"}, image_bytes, 0);
    chk({tag, "_file"}, file_size, 0);
    chk({tag, "_mem"}, {mem_addr, mem_wrdata}, 0);
    chk({tag, "_pix_base"}, pix_base, HDR_BYTES);
  endtask

  // One sub-block phase; d < 0 means the done never arrives.
  task automatic run_phase(input int ph, input int d, input bit noise);
    int n;
    n = (d < 0) ? TMO : d;
    exp_sel = ph;
    for (int k = 0; k <= n; k++) begin
      hdr_done = (ph == 2) ? (k == d) : (noise ? 1'($urandom) : 1'b0);
      pix_done = (ph == 3) ? (k == d) : (noise ? 1'($urandom) : 1'b0);
      start = noise ? 1'($urandom) : 1'b0;
      if (ph == 2) chk("hdr_start_pulse", hdr_start, k == 0);
      else         chk("pix_start_pulse", pix_start, k == 0);
      chk("busy_phase", busy, 1);
      chk("done_phase", done, 0);
      tick;
    end
    hdr_done = 1'b0; pix_done = 1'b0; start = 1'b0;
  endtask

  // Entered on the first cycle after acceptance (CALC).
  task automatic export_body(input exp_t e, input int dh, input int dp, input bit noise);
    exp_sel = 0;
    chk("busy_calc", busy, 1);
    chk("done_calc", done, 0);
    if (noise) begin
      xMin = 11'($urandom); xMax = 11'($urandom); yMin = 11'($urandom); yMax = 11'($urandom);
    end
    tick;
    if (e.err != 2'd1) begin
      run_phase(2, dh, noise);
      if (dh >= 0) run_phase(3, dp, noise);
    end
    exp_sel = 0;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("err_at_done", err, e.err);
    tick;
    chk("done_low_after", done, 0);
    chk("busy_idle", busy, 0);
    chk("err_held", err, e.err);
  endtask

  task automatic run_export(input exp_t e, input int dh, input int dp, input bit noise);
    set_win(e);
    sb_q.push_back(e);
    start = 1'b1;
    tick;
    start = 1'b0;
    export_body(e, dh, dp, noise);
  endtask

  task automatic host_session(input int len, input int start_at, input exp_t e, input int dh, input int dp);
    host_req = 1'b1;
    tick;
    exp_sel = 1;
    for (int k = 0; k < len; k++) begin
      if (k == start_at) begin
        set_win(e);
        sb_q.push_back(e);
        start = 1'b1;
      end
      chk("busy_host", busy, 0);
      tick;
      start = 1'b0;
    end
    host_req = 1'b0;
    tick;
    exp_sel = 0;
    chk("gnt_low_r1", host_gnt, 0);
    chk("busy_low_r1", busy, 0);
    if (start_at >= 0) begin
      tick;
      export_body(e, dh, dp, 1'b0);
    end
  endtask

  task automatic rand_exp(input bit bad, input bit tmo, output exp_t e);
    int a, b, c, d;
    a = $urandom_range(0, 2047); c = $urandom_range(0, 2047);
    b = $urandom_range(a, 2047); d = $urandom_range(c, 2047);
    if (bad) begin
      if ($urandom_range(0, 1) == 0 && a > 0) b = $urandom_range(0, a - 1);
      else if (c > 0) d = $urandom_range(0, c - 1);
      else begin a = 7; b = 3; end
    end
    e = model(a, b, c, d, tmo);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  exp_t e;
  int   kind;
  initial begin
    start = 1'b0; host_req = 1'b0; hdr_done = 1'b0; pix_done = 1'b0;
    xMin = '0; xMax = '0; yMin = '0; yMax = '0;
    rst_n = 1'b0;
    #3;
    check_zero("reset");
    #20;
    tick;
    rst_n = 1'b1;
    tick;

    run_export(model(0, 99, 0, 99, 0), 2, 3, 0);
    run_export(model(10, 14, 0, 2, 0), 0, 0, 0);
    run_export(model(20, 5, 0, 10, 0), 0, 0, 0);
    host_session(4, 1, model(0, 99, 0, 99, 0), 1, 1);
    host_session(3, -1, model(0, 0, 0, 0, 0), 0, 0);
    run_export(model(3, 40, 7, 9, 1), -1, 0, 1);
    run_export(model(0, 2047, 0, 2047, 1), 1, -1, 1);

    // start and host_req together: start wins, host waits until IDLE.
    e = model(5, 6, 7, 8, 0);
    set_win(e);
    sb_q.push_back(e);
    start = 1'b1; host_req = 1'b1;
    tick;
    start = 1'b0;
    export_body(e, 1, 2, 0);
    tick;
    exp_sel = 1;
    chk("gnt_after_idle", host_gnt, 1);
    host_req = 1'b0;
    tick;
    exp_sel = 0;

    // Reset in the middle of the pixel phase.
    e = model(1, 50, 2, 60, 0);
    set_win(e);
    sb_q.push_back(e);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    run_phase(2, 1, 0);
    exp_sel = 3;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midpix_reset");
    sb_q.delete();
    exp_sel = 0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_after_reset", {busy, done, host_gnt}, 0);
    run_export(model(0, 99, 0, 99, 0), 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 6) begin
        rand_exp(1, 0, e); run_export(e, 0, 0, 1);
      end else if (kind == 7) begin
        rand_exp(0, 0, e); host_session($urandom_range(1, 5), 0, e, $urandom_range(0, 6), $urandom_range(0, 6));
      end else if (kind == 8) begin
        rand_exp(0, 0, e); host_session($urandom_range(1, 5), -1, e, 0, 0);
      end else if (kind == 9) begin
        rand_exp(0, 1, e);
        if ($urandom_range(0, 1) == 0) run_export(e, -1, 0, 1);
        else run_export(e, $urandom_range(0, 6), -1, 1);
      end else begin
        rand_exp(0, 0, e); run_export(e, $urandom_range(0, 6), $urandom_range(0, 6), 1);
      end
      tick;
      chk("no_queued_start", busy, 0);
    end

    chk("sb_empty_end", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
